// File: rtl/video_cfg_sequencer_if.sv
// rtl/video_cfg_sequencer_if.sv - video timing, config request and applied-config bundle
// Purpose: groups the pixel timing inputs, the requested configuration and the
//          applied configuration / geometry outputs of video_cfg_sequencer.
// Ports (signals):
//   ce_pix, HSync, VSync             video source timing
//   req_scandoubler_disable, req_hq2x, req_ypbpr, req_scanlines  requested config
//   scandoubler_disable, hq2x, ypbpr, scanlines, blank           applied config
//   line_len, frame_lines, mode_stable, cfg_busy                 geometry / status
// Modports: master = video source and config requester, slave = sequencer.
interface video_cfg_sequencer_if;
  logic        ce_pix;
  logic        HSync;
  logic        VSync;
  logic        req_scandoubler_disable;
  logic        req_hq2x;
  logic        req_ypbpr;
  logic [1:0]  req_scanlines;
  logic        scandoubler_disable;
  logic        hq2x;
  logic        ypbpr;
  logic [1:0]  scanlines;
  logic        blank;
  logic [11:0] line_len;
  logic [9:0]  frame_lines;
  logic        mode_stable;
  logic        cfg_busy;

  modport master (
    output ce_pix, HSync, VSync,
    output req_scandoubler_disable, req_hq2x, req_ypbpr, req_scanlines,
    input  scandoubler_disable, hq2x, ypbpr, scanlines, blank,
    input  line_len, frame_lines, mode_stable, cfg_busy
  );

  modport slave (
    input  ce_pix, HSync, VSync,
    input  req_scandoubler_disable, req_hq2x, req_ypbpr, req_scanlines,
    output scandoubler_disable, hq2x, ypbpr, scanlines, blank,
    output line_len, frame_lines, mode_stable, cfg_busy
  );
endinterface

// File: rtl/video_cfg_sequencer.sv
// rtl/video_cfg_sequencer.sv - frame-synchronous video config sequencer with geometry tracking
// Purpose: measures line length / frame height, flags stable geometry, and applies
//          disruptive video_mixer config changes only inside a blanked window
//          aligned to VSync falls (watchdog-covered if sync is lost).
// Ports:
//   clk_sys  in   sole clock
//   reset    in   synchronous, active-high
//   vid      slave side of video_cfg_sequencer_if (timing in, requests in,
//            applied config, blank, line_len, frame_lines, mode_stable, cfg_busy out)
module video_cfg_sequencer #(
  parameter int STABLE_FRAMES = 2,
  parameter int SETTLE_FRAMES = 2,
  parameter int TIMEOUT_BITS  = 21
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  video_cfg_sequencer_if.slave  vid
);

  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam int SW = $clog2(SETTLE_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_VS = 3'd1,
    S_BLANK   = 3'd2,
    S_APPLY   = 3'd3,
    S_SETTLE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic                    hs_d, vs_d, hs_fall, vs_fall;
  logic [11:0]             pix_cnt, line_len_q;
  logic [9:0]              line_cnt, frame_lines_q, lines_closed;
  logic [MW-1:0]           match_cnt;
  logic [SW-1:0]           settle_cnt;
  logic [TIMEOUT_BITS-1:0] wd_cnt;
  logic                    wd_active, ev, cfg_diff;
  logic                    sd_q, hq2x_q, ypbpr_q;
  logic [1:0]              scanlines_q;
  logic                    lat_sd, lat_hq2x, lat_ypbpr;
  logic [1:0]              lat_scanlines;

  assign hs_fall = hs_d & ~vid.HSync;
  assign vs_fall = vs_d & ~vid.VSync;

  // A line ending in the same cycle as the frame belongs to the closing frame.
  assign lines_closed = (hs_fall && line_cnt != 10'h3FF) ? line_cnt + 10'd1 : line_cnt;

  assign wd_active = (state == S_WAIT_VS) || (state == S_BLANK) || (state == S_SETTLE);
  // Watchdog expiry stands in for a VSync fall so a lost sync cannot wedge the FSM.
  assign ev        = vs_fall || (wd_active && (&wd_cnt));
  assign cfg_diff  = (vid.req_scandoubler_disable != sd_q) ||
                     (vid.req_hq2x != hq2x_q) || (vid.req_ypbpr != ypbpr_q);

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (cfg_diff) state_next = S_WAIT_VS;
      S_WAIT_VS: if (ev)       state_next = S_BLANK;
      S_BLANK:   if (ev)       state_next = S_APPLY;
      S_APPLY:                 state_next = S_SETTLE;
      S_SETTLE:  if (ev && settle_cnt == SW'(SETTLE_FRAMES - 1)) state_next = S_IDLE;
      default:                 state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_d          <= 1'b0;
      vs_d          <= 1'b0;
      pix_cnt       <= '0;
      line_len_q    <= '0;
      line_cnt      <= '0;
      frame_lines_q <= '0;
      match_cnt     <= '0;
      settle_cnt    <= '0;
      wd_cnt        <= '0;
      sd_q          <= 1'b0;
      hq2x_q        <= 1'b0;
      ypbpr_q       <= 1'b0;
      scanlines_q   <= 2'b00;
      lat_sd        <= 1'b0;
      lat_hq2x      <= 1'b0;
      lat_ypbpr     <= 1'b0;
      lat_scanlines <= 2'b00;
    end else begin
      hs_d <= vid.HSync;
      vs_d <= vid.VSync;

      // The ce_pix of the line-end cycle is the first pixel of the new line.
      if (hs_fall) begin
        line_len_q <= pix_cnt;
        pix_cnt    <= {11'd0, vid.ce_pix};
      end else if (vid.ce_pix && pix_cnt != 12'hFFF) begin
        pix_cnt <= pix_cnt + 12'd1;
      end

      if (vs_fall) begin
        frame_lines_q <= lines_closed;
        line_cnt      <= '0;
      end else if (hs_fall && line_cnt != 10'h3FF) begin
        line_cnt <= line_cnt + 10'd1;
      end

      // A newly applied mode must re-earn stability from scratch.
      if (state == S_APPLY) begin
        match_cnt <= '0;
      end else if (vs_fall) begin
        if (lines_closed == frame_lines_q) begin
          if (match_cnt != MW'(STABLE_FRAMES)) match_cnt <= match_cnt + 1'b1;
        end else begin
          match_cnt <= '0;
        end
      end

      if (wd_active && !ev && state_next == state) wd_cnt <= wd_cnt + 1'b1;
      else                                         wd_cnt <= '0;

      if (state == S_APPLY)            settle_cnt <= '0;
      else if (state == S_SETTLE && ev) settle_cnt <= settle_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (cfg_diff) begin
            lat_sd        <= vid.req_scandoubler_disable;
            lat_hq2x      <= vid.req_hq2x;
            lat_ypbpr     <= vid.req_ypbpr;
            lat_scanlines <= vid.req_scanlines;
          end else if (vs_fall && vid.req_scanlines != scanlines_q) begin
            // Scanline level is cosmetic: switch at frame boundary without blanking.
            scanlines_q <= vid.req_scanlines;
          end
        end
        S_APPLY: begin
          sd_q        <= lat_sd;
          hq2x_q      <= lat_hq2x;
          ypbpr_q     <= lat_ypbpr;
          scanlines_q <= lat_scanlines;
        end
        default: ;
      endcase
    end
  end

  assign vid.scandoubler_disable = sd_q;
  assign vid.hq2x                = hq2x_q;
  assign vid.ypbpr               = ypbpr_q;
  assign vid.scanlines           = scanlines_q;
  assign vid.blank               = (state == S_BLANK) || (state == S_APPLY) || (state == S_SETTLE);
  assign vid.cfg_busy            = (state != S_IDLE);
  assign vid.line_len            = line_len_q;
  assign vid.frame_lines         = frame_lines_q;
  assign vid.mode_stable         = (match_cnt == MW'(STABLE_FRAMES));

endmodule

// File: doc/video_cfg_sequencer.md
VIDEO_CFG_SEQUENCER -- requirements
Module: video_cfg_sequencer

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 2: consecutive equal frame measurements required before mode_stable is asserted.
REQ-002 SHALL have parameter SETTLE_FRAMES, default 2: frames blank is held after a disruptive config change.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 21: width of the VSync-wait watchdog counter.
REQ-004 clk_sys  in  1  master clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ce_pix  in  1  pixel clock enable.
REQ-007 HSync, VSync  in  1 each  positive sync pulses; the falling edge marks line end / frame end.
REQ-008 req_scandoubler_disable, req_hq2x, req_ypbpr  in  1 each  requested config, typically from the OSD status word; asynchronous to frame timing.
REQ-009 req_scanlines  in  2  requested scanline level.
REQ-010 scandoubler_disable, hq2x, ypbpr  out  1 each  applied config to video_mixer.
REQ-011 scanlines  out  2  applied scanline level.
REQ-012 blank  out  1  forces mixer RGB to black while high.
REQ-013 line_len  out  12  ce_pix count of the last complete line.
REQ-014 frame_lines  out  10  line count of the last complete frame.
REQ-015 mode_stable  out  1  frame geometry stable.
REQ-016 cfg_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 Edge detection SHALL use HSync/VSync registered once; a falling edge is old=1 and current=0, evaluated every clk_sys.
REQ-018 The pixel counter SHALL count ce_pix pulses and saturate at 4095; on an HSync fall it SHALL load line_len (visible next cycle) and restart at 0, or at 1 if ce_pix is high in that same cycle.
REQ-019 The line counter SHALL count HSync falls and saturate at 1023; on a VSync fall it SHALL load frame_lines and restart at 0.
REQ-020 On a simultaneous HSync fall and VSync fall, the HSync fall SHALL be counted into the frame being closed.
REQ-021 Stability tracking SHALL work as follows on each VSync fall:
- if the new frame_lines equals the previous value, increment a match counter, saturating at STABLE_FRAMES;
- otherwise clear the match counter.
REQ-022 mode_stable SHALL be high exactly when the match counter equals STABLE_FRAMES.
REQ-023 The FSM SHALL have the states IDLE, WAIT_VS, BLANK, APPLY, SETTLE.
REQ-024 In IDLE, a difference in scanlines alone SHALL be applied to the output on the next VSync fall, with no blank and no state change.
REQ-025 In IDLE, a difference between the requested and applied scandoubler_disable, hq2x or ypbpr SHALL latch all four request fields and go to WAIT_VS.
REQ-026 WAIT_VS SHALL go to BLANK on a VSync fall and assert blank from that cycle.
REQ-027 BLANK SHALL go to APPLY on the next VSync fall.
REQ-028 APPLY SHALL last one cycle: it loads the latched fields into the outputs and clears the match counter.
REQ-029 After APPLY the FSM SHALL go to SETTLE.
REQ-030 SETTLE SHALL keep blank high for SETTLE_FRAMES VSync falls, then go to IDLE and deassert blank in the same cycle.
REQ-031 Request changes while not in IDLE SHALL be ignored until IDLE is re-entered; they are then evaluated in the first IDLE cycle.
REQ-032 Watchdog: in WAIT_VS, BLANK and SETTLE, a TIMEOUT_BITS counter SHALL run every clk_sys and clear on each VSync fall or state change.
REQ-033 On watchdog all-ones, the FSM SHALL act as if a VSync fall occurred, to cover lost sync.

Reset
REQ-034 While reset is high, the FSM SHALL go to IDLE and all counters, including the watchdog, SHALL clear.
REQ-035 While reset is high, outputs SHALL be:
- scandoubler_disable=0, hq2x=0, ypbpr=0, scanlines=0;
- blank=0, cfg_busy=0, mode_stable=0;
- line_len=0, frame_lines=0.
REQ-036 Reset asserted mid-sequence (any state) SHALL abort the sequence with no partial apply.
REQ-037 After reset, the first changed request SHALL be processed per REQ-024/REQ-025.

Verification
REQ-038 448 ce_pix per line, 312 lines per frame, 3 frames -> line_len=448 and frame_lines=312; mode_stable rises on the 3rd VSync fall.
REQ-039 With stable video, toggle req_hq2x -> blank rises at the next VSync fall; hq2x=1 one frame later; blank falls 2 frames after that; cfg_busy high throughout.
REQ-040 req_scanlines=2'b10 in IDLE -> scanlines=2'b10 at the next VSync fall; blank stays 0.
REQ-041 VSync held low after a req_ypbpr change -> apply occurs after watchdog expiry (2^21-1 cycles per stage).
REQ-042 Reset pulsed during BLANK -> all outputs at reset values the next cycle; no config applied.
REQ-043 Change frame_lines 312 -> 262 -> mode_stable drops on the mismatching VSync fall and rises again after 2 equal frames.
